capture_readout: RTL
====================

Name: capture_readout

Overview:
Drains the 128K x 8 capture RAM after an acquisition and streams its bytes to the host-link byte transmitter (UART TX) over a valid/ready handshake.
Sits directly downstream of the sampling/trigger stage: that stage fills the RAM through its write port; this block owns the RAM read port.
Readout starts at a programmable base address and covers a programmable byte count, wrapping at the top of the RAM.

Parameters:
ADDR_W, 17, RAM address width
DATA_W, 8, RAM/TX byte width
DEPTH, 131072, RAM depth in bytes; must equal 2**ADDR_W
RD_LAT, 1, RAM read latency in clk_50M cycles (1 or 2)

Ports:
clk_50M  in  1  system clock, 50 MHz
rst_n  in  1  synchronous active-low reset
start  in  1  single-cycle pulse: begin a readout; ignored unless idle
abort  in  1  level; forces return to IDLE
base_addr  in  ADDR_W  first RAM address read; sampled on accepted start
len_m1  in  ADDR_W  byte count minus 1 (0 = 1 byte, DEPTH-1 = full RAM); sampled on accepted start
rd_en  out  1  RAM read enable
rd_addr  out  ADDR_W  RAM read address
rd_data  in  DATA_W  RAM read data, valid RD_LAT cycles after rd_en
tx_data  out  DATA_W  byte to transmitter
tx_valid  out  1  tx_data valid
tx_ready  in  1  transmitter accepts the byte when tx_valid && tx_ready
busy  out  1  high from the cycle after an accepted start until done
done  out  1  single-cycle pulse after the last byte is accepted

Behaviour:
- Reset values, applied on the clk_50M edge while rst_n=0: state=IDLE, rd_en=0, rd_addr=0, tx_data=0, tx_valid=0, busy=0, done=0, internal counters 0.
- FSM states: IDLE, ISSUE, WAIT, SEND, DONE.
- IDLE: start=1 latches base_addr into the address pointer and len_m1 into the remaining count, then goes to ISSUE.
- ISSUE: rd_en=1 for exactly one cycle with rd_addr=pointer; go to WAIT.
- WAIT: lasts RD_LAT cycles. On the last WAIT cycle, capture rd_data into tx_data, set tx_valid=1, go to SEND.
- SEND: hold tx_data and tx_valid stable until tx_ready=1. On handshake:
  - if remaining count = 0, drop tx_valid and go to DONE;
  - otherwise decrement the count, advance the pointer, drop tx_valid and go to ISSUE.
- DONE: done=1 for one cycle, then IDLE. busy is low in IDLE and high in ISSUE, WAIT, SEND and DONE.
- Throughput: one byte per RD_LAT+2 cycles when tx_ready is held high.
- Address pointer advances modulo DEPTH: from DEPTH-1 it wraps to 0. No range error exists.
- start while not in IDLE is ignored, with no effect on the latched parameters.
- abort=1 in any state: next state is IDLE, and tx_valid, rd_en and busy go low on the next edge. done is not pulsed.
- abort and start in the same IDLE cycle: abort wins and the block stays IDLE.
- A byte already presented on tx_data must not change until accepted or aborted.
- Length arithmetic is ADDR_W wide, so the full DEPTH count fits with no overflow.

Optional Feature:
READOUT_CHECKSUM_EN.
- Defined: a running XOR of every byte accepted by the transmitter is kept, cleared on accepted start. After the last data byte is accepted, an extra state CSUM presents the XOR value as one more byte with tx_valid/tx_ready. done pulses after the checksum byte is accepted. Total bytes sent = len_m1+2.
- Undefined: no CSUM state, no checksum logic, exactly len_m1+1 bytes are sent.

Decomposition:
- Shared package la_pkg holds:
  - LA_ADDR_W=17, LA_DATA_W=8, LA_DEPTH=131072 (shared with the sampling stage);
  - the readout state enum (IDLE, ISSUE, WAIT, SEND, CSUM, DONE).
- No sub-module: a single FSM plus datapath. The RD_LAT wait counter stays inline.

Test Plan:
1. RAM preloaded with data = addr[7:0]; base=0, len_m1=3, tx_ready=1 -> bytes 00,01,02,03 on successive handshakes; done pulses once; busy high for 4*(RD_LAT+2)+1 cycles.
2. base=0x1FFFE, len_m1=3 -> rd_addr sequence 1FFFE, 1FFFF, 00000, 00001; bytes FE, FF, 00, 01.
3. tx_ready held low for 10 cycles during the first byte -> tx_data/tx_valid stable for all 10 cycles, no further rd_en, byte is not lost or duplicated.
4. abort asserted in SEND of the 2nd byte -> tx_valid=0 and busy=0 on the next edge, no done pulse; a new start afterwards works from a fresh base.
5. start pulsed again while busy, with different base/len -> ignored; original sequence completes unchanged. rst_n=0 mid-readout -> all outputs at reset values on the next edge.
6. READOUT_CHECKSUM_EN defined, bytes 0x12, 0x34, 0x56 (len_m1=2) -> 4th byte = 0x70, done pulses after it is accepted.

Source files
------------

// File: rtl/la_pkg.sv
// ----------------------------------------------------------------------------
// la_pkg
// Shared definitions for the logic-analyser capture path. The sampling stage
// and the readout block both use the capture RAM geometry defined here.
//
// Contents:
//   LA_ADDR_W       capture RAM address width
//   LA_DATA_W       capture RAM / transmitter byte width
//   LA_DEPTH        capture RAM depth in bytes (2**LA_ADDR_W)
//   readout_state_t readout FSM state encoding
// ----------------------------------------------------------------------------
package la_pkg;

  localparam int LA_ADDR_W = 17;
  localparam int LA_DATA_W = 8;
  localparam int LA_DEPTH  = 131072;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    SEND,
    CSUM,
    DONE
  } readout_state_t;

endpackage

// File: rtl/capture_readout.sv
// ----------------------------------------------------------------------------
// capture_readout
// Drains the capture RAM after an acquisition and streams its bytes to the
// host-link transmitter over a valid/ready handshake. Readout starts at a
// programmable base address, covers len_m1+1 bytes and wraps at the top of
// the RAM. Each byte is fetched with one read (ISSUE), waits RD_LAT cycles
// for RAM data (WAIT), then is held on tx_data until accepted (SEND).
//
// Optional feature (macro READOUT_CHECKSUM_EN):
//   When defined, a running XOR of all accepted data bytes is appended as one
//   extra byte (CSUM state) before done pulses. When undefined, exactly
//   len_m1+1 bytes are sent.
//
// Ports:
//   clk_50M    in   system clock
//   rst_n      in   synchronous active-low reset
//   start      in   one-cycle pulse, begins a readout when idle
//   abort      in   level, forces return to IDLE (wins over start)
//   base_addr  in   first RAM address, sampled on accepted start
//   len_m1     in   byte count minus one, sampled on accepted start
//   rd_en      out  RAM read enable
//   rd_addr    out  RAM read address
//   rd_data    in   RAM read data, valid RD_LAT cycles after rd_en
//   tx_data    out  byte to transmitter
//   tx_valid   out  tx_data valid
//   tx_ready   in   transmitter accepts when tx_valid && tx_ready
//   busy       out  high from the cycle after an accepted start until done
//   done       out  one-cycle pulse after the final byte is accepted
// ----------------------------------------------------------------------------
module capture_readout
  import la_pkg::*;
#(
  parameter int ADDR_W = LA_ADDR_W,
  parameter int DATA_W = LA_DATA_W,
  parameter int DEPTH  = LA_DEPTH,
  parameter int RD_LAT = 1
) (
  input  logic              clk_50M,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] len_m1,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  // Index of the WAIT cycle on which RAM data is valid and gets captured.
  localparam logic [1:0] LAST_WAIT = 2'(RD_LAT - 1);

  readout_state_t    state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] remaining;
  logic [ADDR_W-1:0] next_ptr;
  logic [1:0]        wait_cnt;
`ifdef READOUT_CHECKSUM_EN
  logic [DATA_W-1:0] csum;
`endif

  // Address advance wraps explicitly at the last RAM location.
  always_comb begin
    next_ptr = ptr + 1'b1;
    if (ptr == ADDR_W'(DEPTH - 1)) begin
      next_ptr = '0;
    end
  end

  // Readout FSM with registered outputs. rd_en is raised on entry to ISSUE so
  // it is high for exactly the ISSUE cycle; tx_valid is raised on the last
  // WAIT cycle and dropped on the handshake.
  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
      wait_cnt  <= '0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef READOUT_CHECKSUM_EN
      csum      <= '0;
`endif
    end else if (abort) begin
      state    <= IDLE;
      rd_en    <= 1'b0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            ptr       <= base_addr;
            remaining <= len_m1;
            rd_addr   <= base_addr;
            rd_en     <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
`ifdef READOUT_CHECKSUM_EN
            csum      <= '0;
`endif
          end
        end

        ISSUE: begin
          rd_en    <= 1'b0;
          wait_cnt <= '0;
          state    <= WAIT;
        end

        WAIT: begin
          if (wait_cnt == LAST_WAIT) begin
            tx_data  <= rd_data;
            tx_valid <= 1'b1;
            state    <= SEND;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end

        SEND: begin
          if (tx_ready) begin
`ifdef READOUT_CHECKSUM_EN
            csum <= csum ^ tx_data;
`endif
            if (remaining == '0) begin
`ifdef READOUT_CHECKSUM_EN
              // The checksum byte follows directly; tx_valid stays high.
              tx_data <= csum ^ tx_data;
              state   <= CSUM;
`else
              tx_valid <= 1'b0;
              done     <= 1'b1;
              state    <= DONE;
`endif
            end else begin
              remaining <= remaining - 1'b1;
              ptr       <= next_ptr;
              rd_addr   <= next_ptr;
              rd_en     <= 1'b1;
              tx_valid  <= 1'b0;
              state     <= ISSUE;
            end
          end
        end

`ifdef READOUT_CHECKSUM_EN
        CSUM: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
`endif

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          rd_en    <= 1'b0;
          tx_valid <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
